// File: rtl/data_memory_ls.sv
// Multi-cycle RISC-V load/store data memory: sized, sign/zero-extended accesses with wait states.
// Define DMEM_MISALIGN_CHK_EN to flag misaligned halfword/word accesses as errors.
module data_memory_ls #(
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [2:0]        funct3_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       write_data_i,
   output logic [31:0]       read_data_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);
   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e            r_state, w_state_d;
   logic [3:0]        r_cnt, w_cnt_d;
   logic              r_st;
   logic [2:0]        r_f3;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [31:0]       r_rdata;
   logic              r_err;
   logic [31:0]       r_mem [DEPTH];

   logic              w_accept, w_commit;
   logic              w_st;
   logic [2:0]        w_f3;
   logic [ADDR_W-1:0] w_addr;
   logic [31:0]       w_wdata;
   logic [ADDR_W-3:0] w_idx;
   logic [AW-1:0]     w_word;
   logic [1:0]        w_off;
   logic              w_f3_bad, w_oob, w_misalign, w_err;
   logic [3:0]        w_be;
   logic [31:0]       w_wlane, w_rshift, w_ldata;

   assign w_accept = (r_state == StIdle) && (MemRead || MemWrite);

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_commit  = 1'b0;
      case (r_state)
         StIdle: begin
            if (w_accept) begin
               w_commit  = (WAIT_CYCLES == 0);
               w_state_d = (WAIT_CYCLES == 0) ? StResp : StWait;
               w_cnt_d   = 4'd1;
            end
         end
         StWait: begin
            if (r_cnt == 4'(WAIT_CYCLES)) begin
               w_state_d = StResp;
               w_commit  = 1'b1;
            end else begin
               w_cnt_d = r_cnt + 4'd1;
            end
         end
         StResp: begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
         end
         default: w_state_d = StIdle;
      endcase
   end

   // With zero wait states the commit edge is the accepting edge, so use the live inputs.
   assign w_st    = (r_state == StIdle) ? MemWrite     : r_st;
   assign w_f3    = (r_state == StIdle) ? funct3_i     : r_f3;
   assign w_addr  = (r_state == StIdle) ? addr_i       : r_addr;
   assign w_wdata = (r_state == StIdle) ? write_data_i : r_wdata;

   assign w_idx    = w_addr[ADDR_W-1:2];
   assign w_word   = w_idx[AW-1:0];
   assign w_oob    = (w_idx >> AW) != '0;
   assign w_f3_bad = w_st ? (w_f3 > 3'd2)
                          : ((w_f3[1:0] == 2'b11) || (w_f3[2:1] == 2'b11));

`ifdef DMEM_MISALIGN_CHK_EN
   assign w_misalign = ((w_f3[1:0] == 2'b01) && w_addr[0]) ||
                       ((w_f3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
`else
   assign w_misalign = 1'b0;
`endif

   assign w_err = w_f3_bad || w_oob || w_misalign;

   always_comb begin
      w_off = w_addr[1:0];
      w_be  = 4'b1111;
      case (w_f3[1:0])
         2'b00: w_be = 4'b0001 << w_addr[1:0];
         2'b01: begin
            w_off = {w_addr[1], 1'b0};
            w_be  = 4'b0011 << {w_addr[1], 1'b0};
         end
         default: w_off = 2'b00;
      endcase
   end

   assign w_wlane  = w_wdata << {w_off, 3'b000};
   assign w_rshift = r_mem[w_word] >> {w_off, 3'b000};

   always_comb begin
      case (w_f3[1:0])
         2'b00:   w_ldata = {{24{~w_f3[2] & w_rshift[7]}}, w_rshift[7:0]};
         2'b01:   w_ldata = {{16{~w_f3[2] & w_rshift[15]}}, w_rshift[15:0]};
         default: w_ldata = w_rshift;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      end else if (w_commit && w_st && !w_err) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_word][8*b +: 8] <= w_wlane[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_st    <= 1'b0;
         r_f3    <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         if (w_accept) begin
            r_st    <= MemWrite;
            r_f3    <= funct3_i;
            r_addr  <= addr_i;
            r_wdata <= write_data_i;
         end
         if (w_commit) begin
            r_err <= w_err;
            if (!w_st) r_rdata <= w_err ? '0 : w_ldata;
         end
      end
   end

   assign read_data_o = r_rdata;
   assign busy_o      = (r_state != StIdle);
   assign done_o      = (r_state == StResp);
   assign err_o       = done_o && r_err;

endmodule

// File: tb/tb_data_memory_ls.sv
// Self-checking bench for data_memory_ls: directed vector table, corner sequences, and
// randomized accesses against a byte-array reference model.
module tb_data_memory_ls;
   localparam int unsigned DEPTH       = 64;
   localparam int unsigned ADDR_W      = 32;
   localparam int unsigned WAIT_CYCLES = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        MemRead = 1'b0;
   logic        MemWrite = 1'b0;
   logic [2:0]  funct3_i = '0;
   logic [31:0] addr_i = '0;
   logic [31:0] write_data_i = '0;
   logic [31:0] read_data_o;
   logic        busy_o, done_o, err_o;

   int checks = 0;
   int failures = 0;

   bit [7:0]  m_mem [4*DEPTH];
   bit [31:0] m_rd;

   typedef struct {
      bit        re;
      bit        we;
      bit [2:0]  f3;
      bit [31:0] a;
      bit [31:0] wd;
      bit [31:0] exp_rd;
      bit        exp_err;
      string     name;
   } vec_t;

   vec_t vt[$];

   always #5 clk = ~clk;

   data_memory_ls #(
      .DEPTH       (DEPTH),
      .ADDR_W      (ADDR_W),
      .WAIT_CYCLES (WAIT_CYCLES)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .MemRead      (MemRead),
      .MemWrite     (MemWrite),
      .funct3_i     (funct3_i),
      .addr_i       (addr_i),
      .write_data_i (write_data_i),
      .read_data_o  (read_data_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .err_o        (err_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      foreach (m_mem[i]) m_mem[i] = 8'h00;
      m_rd = '0;
   endtask

   // Behavioural reference: memory as a flat byte array, addressed little-endian.
   task automatic model_access(input bit st, input bit [2:0] f3, input bit [31:0] a,
                               input bit [31:0] wd, output bit [31:0] rd, output bit err);
      int unsigned sz;
      bit [31:0]   ea, val, mask;
      sz  = 1 << f3[1:0];
      err = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      if ((a >> 2) >= DEPTH) err = 1'b1;
`ifdef DMEM_MISALIGN_CHK_EN
      if (!err && (a % sz) != 0) err = 1'b1;
`endif
      if (err) begin
         if (!st) m_rd = '0;
      end else begin
         ea = a - (a % sz);
         if (st) begin
            for (int i = 0; i < int'(sz); i++) m_mem[ea+i] = wd[8*i +: 8];
         end else begin
            val = '0;
            for (int i = 0; i < int'(sz); i++) val = val | (32'(m_mem[ea+i]) << (8*i));
            mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*sz)) - 32'd1);
            if (!f3[2] && val[8*sz-1]) val = val | ~mask;
            m_rd = val;
         end
      end
      rd = m_rd;
   endtask

   task automatic do_access(input bit re, input bit we, input bit [2:0] f3, input bit [31:0] a,
                            input bit [31:0] wd, output logic [31:0] rd, output logic e);
      int n;
      bit got;
      @(posedge clk);
      #1;
      MemRead = re; MemWrite = we; funct3_i = f3; addr_i = a; write_data_i = wd;
      @(posedge clk);
      #1;
      MemRead = 1'b0; MemWrite = 1'b0;
      n = 0; got = 1'b0;
      while (n < 40 && !got) begin
         @(negedge clk);
         n++;
         if (n == 1 && WAIT_CYCLES > 0) chk("busy_in_wait", busy_o, 1);
         if (done_o) got = 1'b1;
      end
      chk("done_seen", got, 1);
      chk("latency", n, WAIT_CYCLES + 1);
      rd = read_data_o;
      e  = err_o;
      @(negedge clk);
      chk("done_one_cycle", done_o, 0);
      chk("err_low_no_done", err_o, 0);
      chk("busy_idle", busy_o, 0);
   endtask

   task automatic add(input bit re, input bit we, input bit [2:0] f3, input bit [31:0] a,
                      input bit [31:0] wd, input bit [31:0] exp_rd, input bit exp_err,
                      input string name);
      vec_t v;
      v.re = re; v.we = we; v.f3 = f3; v.a = a; v.wd = wd;
      v.exp_rd = exp_rd; v.exp_err = exp_err; v.name = name;
      vt.push_back(v);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rd;
      logic        e;
      bit   [31:0] mrd;
      bit          merr;
      int          n;
      bit          got;

      // Directed table: reads expect the held value for stores.
      add(0, 1, 3'b010,  8, 32'hAABBCCDD, 32'h0000_0000, 0, "sw8");
      add(1, 0, 3'b010,  8, 32'h0,        32'hAABBCCDD,  0, "lw8");
      add(0, 1, 3'b010, 12, 32'h12345678, 32'hAABBCCDD,  0, "sw12");
      add(0, 1, 3'b000, 13, 32'h1234569A, 32'hAABBCCDD,  0, "sb13");
      add(1, 0, 3'b010, 12, 32'h0,        32'h12349A78,  0, "lw12");
      add(1, 0, 3'b000, 13, 32'h0,        32'hFFFFFF9A,  0, "lb13");
      add(1, 0, 3'b100, 13, 32'h0,        32'h0000009A,  0, "lbu13");
      add(0, 1, 3'b001, 18, 32'hDEAD8001, 32'h0000009A,  0, "sh18");
      add(1, 0, 3'b001, 18, 32'h0,        32'hFFFF8001,  0, "lh18");
      add(1, 0, 3'b101, 18, 32'h0,        32'h00008001,  0, "lhu18");
      add(1, 0, 3'b010, 20, 32'h0,        32'h0000_0000, 0, "lw20");
      add(1, 0, 3'b010, 4*DEPTH, 32'h0,   32'h0000_0000, 1, "lw_oob");
      add(0, 1, 3'b011, 12, 32'hFFFFFFFF, 32'h0000_0000, 1, "sw_bad_f3");
      add(1, 0, 3'b010, 12, 32'h0,        32'h12349A78,  0, "lw12_again");
`ifdef DMEM_MISALIGN_CHK_EN
      add(0, 1, 3'b010,  9, 32'h11111111, 32'h12349A78,  1, "sw9_misalign");
      add(1, 0, 3'b010,  8, 32'h0,        32'hAABBCCDD,  0, "lw8_after");
      add(1, 0, 3'b001, 19, 32'h0,        32'h0000_0000, 1, "lh19_misalign");
`else
      add(0, 1, 3'b010,  9, 32'h11111111, 32'h12349A78,  0, "sw9_forced");
      add(1, 0, 3'b010,  8, 32'h0,        32'h11111111,  0, "lw8_after");
      add(1, 0, 3'b001, 19, 32'h0,        32'hFFFF8001,  0, "lh19_forced");
`endif
      add(1, 0, 3'b111,  8, 32'h0,        32'h0000_0000, 1, "lw_bad_f3");
      add(1, 1, 3'b000, 21, 32'h000000C3, 32'h0000_0000, 0, "both_is_store");
      add(1, 0, 3'b100, 21, 32'h0,        32'h000000C3,  0, "lbu21");

      rst = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_rdata", read_data_o, 0);
      rst = 1'b1;

      for (int i = 0; i < vt.size(); i++) begin
         model_access(vt[i].we, vt[i].f3, vt[i].a, vt[i].wd, mrd, merr);
         do_access(vt[i].re, vt[i].we, vt[i].f3, vt[i].a, vt[i].wd, rd, e);
         chk({vt[i].name, "_rd"}, rd, vt[i].exp_rd);
         chk({vt[i].name, "_err"}, e, vt[i].exp_err);
      end

      // Store request held high through WAIT with new operands must not be re-accepted.
      model_access(1, 3'b010, 24, 32'h55555555, mrd, merr);
      @(posedge clk);
      #1;
      MemWrite = 1'b1; funct3_i = 3'b010; addr_i = 24; write_data_i = 32'h55555555;
      @(posedge clk);
      #1;
      addr_i = 28; write_data_i = 32'h66666666;
      n = 0; got = 1'b0;
      while (n < 40 && !got) begin
         @(negedge clk);
         n++;
         if (done_o) got = 1'b1;
      end
      MemWrite = 1'b0;
      chk("hold_done_seen", got, 1);
      chk("hold_latency", n, WAIT_CYCLES + 1);
      @(negedge clk);
      chk("hold_idle", busy_o, 0);
      model_access(0, 3'b010, 24, 0, mrd, merr);
      do_access(1, 0, 3'b010, 24, 0, rd, e);
      chk("hold_lw24", rd, mrd);
      model_access(0, 3'b010, 28, 0, mrd, merr);
      do_access(1, 0, 3'b010, 28, 0, rd, e);
      chk("hold_lw28", rd, mrd);

      // Reset pulsed during WAIT aborts the store.
      @(posedge clk);
      #1;
      MemWrite = 1'b1; funct3_i = 3'b010; addr_i = 32; write_data_i = 32'h77777777;
      @(posedge clk);
      #1;
      MemWrite = 1'b0;
      @(negedge clk);
      chk("abort_busy_before", busy_o, 1);
      rst = 1'b0;
      #1;
      chk("abort_busy", busy_o, 0);
      chk("abort_done", done_o, 0);
      chk("abort_rdata", read_data_o, 0);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      model_access(0, 3'b010, 32, 0, mrd, merr);
      do_access(1, 0, 3'b010, 32, 0, rd, e);
      chk("abort_lw32", rd, mrd);
      chk("abort_lw32_err", e, merr);

      // Randomized accesses against the model.
      for (int k = 0; k < 150; k++) begin
         bit        re, we;
         bit [2:0]  f3;
         bit [31:0] a, wd;
         int        mode;
         bit [2:0]  legal [5];
         legal = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
         mode = $urandom_range(0, 2);
         re = (mode != 1);
         we = (mode != 0);
         f3 = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0) f3 = legal[$urandom_range(0, 4)];
         a  = $urandom_range(0, 4*DEPTH + 7);
         if ($urandom_range(0, 15) == 0) a = $urandom;
         wd = $urandom;
         model_access(we, f3, a, wd, mrd, merr);
         do_access(re, we, f3, a, wd, rd, e);
         chk("rand_rd", rd, mrd);
         chk("rand_err", e, merr);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/data_memory_ls.md
DATA_MEMORY_LS -- requirements
Module: data_memory_ls

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, giving the number of 32-bit words; it SHALL be a power of two, from 4 to 4096.
REQ-002 The block SHALL have parameter ADDR_W, default 32, giving the byte-address width.
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 1, giving the extra access wait states; the legal range SHALL be 0..15.
REQ-004 Port clk SHALL be an input, 1 bit: the single clock, rising edge.
REQ-005 Port rst SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-006 Port MemRead SHALL be an input, 1 bit: load request.
REQ-007 Port MemWrite SHALL be an input, 1 bit: store request.
REQ-008 Port funct3_i SHALL be an input, 3 bits: RISC-V load/store size code.
REQ-009 Port addr_i SHALL be an input, ADDR_W bits: byte address.
REQ-010 Port write_data_i SHALL be an input, 32 bits: store data, right-aligned.
REQ-011 Port read_data_o SHALL be an output, 32 bits: registered, extended load result.
REQ-012 Port busy_o SHALL be an output, 1 bit: high while the block is not in IDLE.
REQ-013 Port done_o SHALL be an output, 1 bit: one-cycle completion pulse.
REQ-014 Port err_o SHALL be an output, 1 bit: error flag, valid while done_o is high.

Function
REQ-015 The FSM SHALL have three states, IDLE, WAIT and RESP, with these transitions:
- IDLE->WAIT when a request is accepted and WAIT_CYCLES>0.
- IDLE->RESP when a request is accepted and WAIT_CYCLES=0.
- WAIT->RESP when the wait counter reaches WAIT_CYCLES.
- RESP->IDLE unconditionally.
REQ-016 A request SHALL be accepted only in IDLE with MemRead|MemWrite=1; the accepting edge latches op, funct3_i, addr_i and write_data_i.
REQ-017 Requests presented while busy_o=1 SHALL be ignored, not queued.
REQ-018 When MemRead=MemWrite=1, the request SHALL be treated as a store.
REQ-019 done_o SHALL be high exactly WAIT_CYCLES+1 cycles after the accepting edge, for one cycle (the RESP state); busy_o SHALL equal (state!=IDLE).
REQ-020 Store commit and load capture SHALL occur on the edge entering RESP; stores SHALL be written with per-byte enables on little-endian lanes.
- SB: lane addr[1:0].
- SH: lanes addr[1]*2 and addr[1]*2+1.
- SW: all four lanes.
REQ-021 Load extraction SHALL be:
- LB (000): sign-extend the addressed byte.
- LH (001): sign-extend the addressed halfword.
- LW (010): whole word.
- LBU (100): zero-extend the addressed byte.
- LHU (101): zero-extend the addressed halfword.
REQ-022 The word index SHALL be addr[ADDR_W-1:2]; an index >= DEPTH SHALL be an error.
REQ-023 Store funct3 values other than 000/001/010, and load funct3 values 011/110/111, SHALL be errors.
REQ-024 On an error, err_o=1 with done_o, no memory byte SHALL change, and read_data_o SHALL be 0 for loads.
REQ-025 read_data_o SHALL hold its value until the next load completes; stores SHALL NOT alter it.
REQ-026 err_o SHALL be 0 whenever done_o=0.

Reset
REQ-027 When rst=0, asynchronously: state=IDLE, wait counter=0, read_data_o=0, busy_o=0, done_o=0, err_o=0, and every memory word=0.
REQ-028 A reset asserted in WAIT SHALL abort the access with no write committed.

Configuration
REQ-029 With DMEM_MISALIGN_CHK_EN defined, LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, SHALL produce err_o=1 and no write.
REQ-030 Without DMEM_MISALIGN_CHK_EN, alignment SHALL be forced by ignoring addr[0] for halfword accesses and addr[1:0] for word accesses, with no error.

Verification
REQ-031 Reset; SW 0xAABBCCDD to 8; LW from 8 -> read_data_o=0xAABBCCDD, err_o=0, done_o at acceptance+WAIT_CYCLES+1.
REQ-032 SW 0x12345678 to 12; SB 0x9A to 13; LW 12 -> 0x12349A78; LB 13 -> 0xFFFFFF9A; LBU 13 -> 0x0000009A.
REQ-033 SH 0x8001 to 18; LH 18 -> 0xFFFF8001; LHU 18 -> 0x00008001; LW from unwritten 20 -> 0x00000000.
REQ-034 LW from 4*DEPTH -> err_o=1, read_data_o=0; SW with funct3=011 -> err_o=1, memory unchanged.
REQ-035 With the macro defined, SW 0x11111111 to 9 -> err_o=1 and word 8 unchanged; without it, word 8 = 0x11111111 and err_o=0.
REQ-036 MemWrite held high during WAIT -> second request ignored; rst pulsed low in WAIT -> busy_o=0 immediately, word unchanged (reads 0).
